// File: rtl/dma_xfer_sequencer.sv
// dma_xfer_sequencer -- fixed-priority, multi-channel DMA transfer sequencer.
//
// Implements the classic SI/SO/S1..S4 bus-cycle sequence. A channel is
// eligible when it requests, is unmasked and holds a non-expired count.
// The winner is latched into activeCh and serviced as a single or block
// transfer. Each channel's count, armed and terminal-count state lives
// in a dma_ch_slot instance.
//
// Build option: define DMA_AUTOINIT_EN for autoinitialisation. A base
// count is then kept per channel and reloaded at terminal count, and the
// channel stays armed. Without the macro the count wraps and the channel
// disarms.
//
// Ports:
//   CLK, RESET          clock, asynchronous active-high reset
//   DREQ[NUM_CH]        per-channel request
//   HLDA                bus grant from host
//   READY               low in S3 inserts wait states
//   CS_N                low = host programming access, blocks new starts
//   chEnable[NUM_CH]    channel unmask
//   blockMode[NUM_CH]   1 = block transfer, 0 = single transfer
//   xferType[2*NUM_CH]  per channel: 01 write, 10 read, 00/11 verify
//   loadCount[NUM_CH]   strobe, load countIn into that channel
//   countIn[CNT_W]      word count (N gives N+1 transfers)
//   HRQ, AEN, ADSTB     hold request, address enable, address strobe
//   DACK[NUM_CH]        one-hot acknowledge
//   IOR_N/IOW_N/MEMR_N/MEMW_N  active-low strobes
//   EOP                 terminal-count pulse (in S4)
//   tcStatus[NUM_CH]    sticky terminal-count flags
//   incrAddr            address-advance pulse (in S4)
//   activeCh            latched serviced channel

module dma_ch_slot #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] cnt_in,
    output logic [CNT_W-1:0] count,
    output logic             armed,
    output logic             tc_flag
);
    // Terminal count is the transfer made while the count is already zero.
    logic is_tc;
    assign is_tc = dec && (count == '0);

`ifdef DMA_AUTOINIT_EN
    logic [CNT_W-1:0] base;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       base <= '0;
        else if (load) base <= cnt_in;
    end
`endif

    // A decrement takes priority over a load. The top level already blocks
    // loads to the channel in service outside SI, so the two never collide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= '0;
            armed   <= 1'b0;
            tc_flag <= 1'b0;
        end else if (dec) begin
`ifdef DMA_AUTOINIT_EN
            count <= is_tc ? base : count - CNT_W'(1);
            if (is_tc) tc_flag <= 1'b1;
`else
            // At zero the count simply wraps to all-ones.
            count <= count - CNT_W'(1);
            if (is_tc) begin
                tc_flag <= 1'b1;
                armed   <= 1'b0;
            end
`endif
        end else if (load) begin
            count   <= cnt_in;
            armed   <= 1'b1;
            tc_flag <= 1'b0;
        end
    end
endmodule

module dma_xfer_sequencer #(
    parameter  int NUM_CH = 4,
    parameter  int CNT_W  = 16,
    localparam int AW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [NUM_CH-1:0]     DREQ,
    input  logic                  HLDA,
    input  logic                  READY,
    input  logic                  CS_N,
    input  logic [NUM_CH-1:0]     chEnable,
    input  logic [NUM_CH-1:0]     blockMode,
    input  logic [2*NUM_CH-1:0]   xferType,
    input  logic [NUM_CH-1:0]     loadCount,
    input  logic [CNT_W-1:0]      countIn,
    output logic                  HRQ,
    output logic                  AEN,
    output logic                  ADSTB,
    output logic [NUM_CH-1:0]     DACK,
    output logic                  IOR_N,
    output logic                  IOW_N,
    output logic                  MEMR_N,
    output logic                  MEMW_N,
    output logic                  EOP,
    output logic [NUM_CH-1:0]     tcStatus,
    output logic                  incrAddr,
    output logic [AW-1:0]         activeCh
);
    localparam logic [5:0] SI = 6'b000001;
    localparam logic [5:0] SO = 6'b000010;
    localparam logic [5:0] S1 = 6'b000100;
    localparam logic [5:0] S2 = 6'b001000;
    localparam logic [5:0] S3 = 6'b010000;
    localparam logic [5:0] S4 = 6'b100000;

    logic [5:0]                   state, nxt;
    logic [NUM_CH-1:0]            armed, eligible;
    logic [NUM_CH-1:0][CNT_W-1:0] cnt;
    logic [AW-1:0]                win;
    logic                         any_req, start, tc_now;
    logic                         st_si, st_s1, st_s4, xfer_on;
    logic [1:0]                   xt;

    assign st_si = state[0];
    assign st_s1 = state[2];
    assign st_s4 = state[5];
    assign xfer_on = state[3] | state[4];

    assign eligible = DREQ & chEnable & armed;
    assign any_req  = |eligible;
    assign start    = st_si && any_req && CS_N;
    assign tc_now   = st_s4 && (cnt[activeCh] == '0);

    // Fixed priority: scanning downward leaves the lowest index as winner.
    always_comb begin
        win = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (eligible[i]) win = AW'(i);
    end

    always_comb begin
        nxt = state;
        case (state)
            SI: if (start) nxt = SO;
            SO: begin
                if (HLDA)                   nxt = S1;
                else if (!DREQ[activeCh])   nxt = SI;
            end
            S1: nxt = S2;
            S2: nxt = S3;
            S3: if (READY) nxt = S4;
            S4: nxt = (blockMode[activeCh] && !tc_now && HLDA) ? S1 : SI;
            default: nxt = SI;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= SI;
            activeCh <= '0;
        end else begin
            state <= nxt;
            if (start) activeCh <= win;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_ch
            logic hit, ld, dc;
            assign hit = (activeCh == AW'(g));
            // The channel in service cannot be reprogrammed mid-sequence.
            assign ld  = loadCount[g] && !(hit && !st_si);
            assign dc  = st_s4 && hit;

            dma_ch_slot #(.CNT_W(CNT_W)) u_slot (
                .clk     (CLK),
                .rst     (RESET),
                .load    (ld),
                .dec     (dc),
                .cnt_in  (countIn),
                .count   (cnt[g]),
                .armed   (armed[g]),
                .tc_flag (tcStatus[g])
            );
        end
    endgenerate

    // Outputs decode straight from the state register. An asynchronous
    // reset therefore drops every strobe without waiting for a clock.
    assign xt       = xferType[{activeCh, 1'b0} +: 2];
    assign HRQ      = !st_si;
    assign AEN      = |state[5:2];
    assign ADSTB    = st_s1;
    assign DACK     = (|state[4:2]) ? (NUM_CH'(1) << activeCh) : '0;
    assign IOR_N    = !(xfer_on && xt == 2'b01);
    assign MEMW_N   = !(xfer_on && xt == 2'b01);
    assign IOW_N    = !(xfer_on && xt == 2'b10);
    assign MEMR_N   = !(xfer_on && xt == 2'b10);
    assign EOP      = tc_now;
    assign incrAddr = st_s4;
endmodule

// File: tb/tb_dma_xfer_sequencer.sv
module tb_dma_xfer_sequencer;
    logic        CLK, RESET, HLDA, READY, CS_N;
    logic [3:0]  DREQ, chEnable, blockMode, loadCount;
    logic [7:0]  xferType;
    logic [15:0] countIn;
    logic        HRQ, AEN, ADSTB, IOR_N, IOW_N, MEMR_N, MEMW_N, EOP, incrAddr;
    logic [3:0]  DACK, tcStatus;
    logic [1:0]  activeCh;

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct packed { logic [1:0] ch; logic eop; } ev_t;
    ev_t exp_q[$];
    ev_t obs_q[$];

    dma_xfer_sequencer #(.NUM_CH(4), .CNT_W(16)) dut (
        .CLK(CLK), .RESET(RESET), .DREQ(DREQ), .HLDA(HLDA), .READY(READY),
        .CS_N(CS_N), .chEnable(chEnable), .blockMode(blockMode),
        .xferType(xferType), .loadCount(loadCount), .countIn(countIn),
        .HRQ(HRQ), .AEN(AEN), .ADSTB(ADSTB), .DACK(DACK), .IOR_N(IOR_N),
        .IOW_N(IOW_N), .MEMR_N(MEMR_N), .MEMW_N(MEMW_N), .EOP(EOP),
        .tcStatus(tcStatus), .incrAddr(incrAddr), .activeCh(activeCh)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Logs every S4 (address advance) with the channel and EOP seen.
    always @(negedge CLK)
        if (!RESET && incrAddr) obs_q.push_back(ev_t'{activeCh, EOP});

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic load_ch(input int ch, input logic [15:0] n);
        loadCount = 4'b0001 << ch;
        countIn = n;
        tick();
        loadCount = 4'b0000;
    endtask

    task automatic test_reset();
        #1;
        total_cnt++;
        if ({HRQ, AEN, ADSTB, EOP, incrAddr} !== 5'b0)
            $display("FAIL reset_ctrl: got %b want 00000", {HRQ, AEN, ADSTB, EOP, incrAddr});
        else pass_cnt++;
        total_cnt++;
        if ({IOR_N, IOW_N, MEMR_N, MEMW_N} !== 4'b1111 || DACK !== 4'b0)
            $display("FAIL reset_strobes: got strobes=%b dack=%b want 1111/0000", {IOR_N, IOW_N, MEMR_N, MEMW_N}, DACK);
        else pass_cnt++;
        total_cnt++;
        if (tcStatus !== 4'b0 || activeCh !== 2'd0)
            $display("FAIL reset_status: got tc=%b ch=%0d want 0000/0", tcStatus, activeCh);
        else pass_cnt++;
        tick();
        RESET = 1'b0;
        tick();
    endtask

    task automatic test_single();
        ev_t e, o;
        chEnable = 4'b0001; blockMode = 4'b0; xferType = 8'b00_00_00_01;
        HLDA = 1'b0; READY = 1'b1;
        load_ch(0, 16'd0);
        exp_q.push_back(ev_t'{2'd0, 1'b1});
        DREQ = 4'b0001;
        tick();
        total_cnt++;
        if ({HRQ, AEN, ADSTB, DACK} !== 7'b1000000) $display("FAIL single_so1: got %b want 1000000", {HRQ, AEN, ADSTB, DACK});
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({HRQ, AEN, ADSTB, DACK} !== 7'b1000000) $display("FAIL single_so2: got %b want 1000000", {HRQ, AEN, ADSTB, DACK});
        else pass_cnt++;
        HLDA = 1'b1;
        tick();
        DREQ = 4'b0;
        total_cnt++;
        if ({HRQ, AEN, ADSTB, DACK, IOR_N, IOW_N, MEMR_N, MEMW_N} !== 11'b111_0001_1111)
            $display("FAIL single_s1: got %b want 11100011111", {HRQ, AEN, ADSTB, DACK, IOR_N, IOW_N, MEMR_N, MEMW_N});
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({ADSTB, DACK, IOR_N, IOW_N, MEMR_N, MEMW_N} !== 9'b0_0001_0110)
            $display("FAIL single_s2: got %b want 000010110", {ADSTB, DACK, IOR_N, IOW_N, MEMR_N, MEMW_N});
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({ADSTB, DACK, IOR_N, IOW_N, MEMR_N, MEMW_N, incrAddr} !== 10'b0_0001_0110_0)
            $display("FAIL single_s3: got %b want 0000101100", {ADSTB, DACK, IOR_N, IOW_N, MEMR_N, MEMW_N, incrAddr});
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({HRQ, AEN, incrAddr, EOP, DACK, IOR_N, IOW_N, MEMR_N, MEMW_N} !== 12'b1111_0000_1111)
            $display("FAIL single_s4: got %b want 111100001111", {HRQ, AEN, incrAddr, EOP, DACK, IOR_N, IOW_N, MEMR_N, MEMW_N});
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({HRQ, EOP, tcStatus} !== 6'b00_0001) $display("FAIL single_idle: got %b want 000001", {HRQ, EOP, tcStatus});
        else pass_cnt++;
        HLDA = 1'b0;
        total_cnt++;
        if (obs_q.size() != exp_q.size()) $display("FAIL single_events: got %0d want %0d", obs_q.size(), exp_q.size());
        else pass_cnt++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total_cnt++;
            if (o !== e) $display("FAIL single_ev: got ch%0d eop%b want ch%0d eop%b", o.ch, o.eop, e.ch, e.eop);
            else pass_cnt++;
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_priority();
        ev_t e, o;
        logic rd_ok, vfy_bad;
        rd_ok = 1'b0; vfy_bad = 1'b0;
        chEnable = 4'b1111; blockMode = 4'b0; xferType = 8'b00_00_10_01;
        loadCount = 4'b1010; countIn = 16'd0;
        tick();
        loadCount = 4'b0;
        exp_q.push_back(ev_t'{2'd1, 1'b1});
        exp_q.push_back(ev_t'{2'd3, 1'b1});
        HLDA = 1'b1; DREQ = 4'b1010;
        for (int c = 0; c < 40 && obs_q.size() < 2; c++) begin
            tick();
            if (DACK[1]) DREQ[1] = 1'b0;
            if (DACK[3]) DREQ[3] = 1'b0;
            if (DACK == 4'b0010 && !ADSTB && {IOW_N, MEMR_N} == 2'b00 && {IOR_N, MEMW_N} == 2'b11) rd_ok = 1'b1;
            if (DACK == 4'b1000 && {IOR_N, IOW_N, MEMR_N, MEMW_N} != 4'b1111) vfy_bad = 1'b1;
        end
        tick();
        total_cnt++;
        if ({rd_ok, vfy_bad} !== 2'b10) $display("FAIL prio_strobes: got rd_ok=%b vfy_bad=%b want 1/0", rd_ok, vfy_bad);
        else pass_cnt++;
        total_cnt++;
        if ({HRQ, tcStatus} !== 5'b0_1011) $display("FAIL prio_idle: got %b want 01011", {HRQ, tcStatus});
        else pass_cnt++;
        HLDA = 1'b0; DREQ = 4'b0;
        total_cnt++;
        if (obs_q.size() != exp_q.size()) $display("FAIL prio_events: got %0d want %0d", obs_q.size(), exp_q.size());
        else pass_cnt++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total_cnt++;
            if (o !== e) $display("FAIL prio_ev: got ch%0d eop%b want ch%0d eop%b", o.ch, o.eop, e.ch, e.eop);
            else pass_cnt++;
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_block();
        ev_t e, o;
        int s1n, incn;
        logic gap;
        s1n = 0; incn = 0; gap = 1'b0;
        chEnable = 4'b1111; blockMode = 4'b0100; xferType = 8'b00_10_00_00;
        load_ch(2, 16'd3);
        for (int i = 0; i < 3; i++) exp_q.push_back(ev_t'{2'd2, 1'b0});
        exp_q.push_back(ev_t'{2'd2, 1'b1});
        HLDA = 1'b1; DREQ = 4'b0100;
        for (int c = 0; c < 60 && incn < 4; c++) begin
            tick();
            if (ADSTB) begin s1n++; DREQ = 4'b0; end
            if (incrAddr) incn++;
            if (HRQ !== 1'b1) gap = 1'b1;
        end
        tick();
        total_cnt++;
        if (s1n != 4 || gap !== 1'b0) $display("FAIL block_s1: got s1=%0d gap=%b want 4/0", s1n, gap);
        else pass_cnt++;
        total_cnt++;
        if ({HRQ, tcStatus[2]} !== 2'b01) $display("FAIL block_idle: got %b want 01", {HRQ, tcStatus[2]});
        else pass_cnt++;
        HLDA = 1'b0; blockMode = 4'b0;
        total_cnt++;
        if (obs_q.size() != exp_q.size()) $display("FAIL block_events: got %0d want %0d", obs_q.size(), exp_q.size());
        else pass_cnt++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total_cnt++;
            if (o !== e) $display("FAIL block_ev: got ch%0d eop%b want ch%0d eop%b", o.ch, o.eop, e.ch, e.eop);
            else pass_cnt++;
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_ready();
        ev_t e, o;
        logic found, lowok;
        found = 1'b0; lowok = 1'b1;
        chEnable = 4'b1111; blockMode = 4'b0; xferType = 8'b00_00_00_01;
        load_ch(0, 16'd1);
        exp_q.push_back(ev_t'{2'd0, 1'b0});
        exp_q.push_back(ev_t'{2'd0, 1'b1});
        DREQ = 4'b0001; HLDA = 1'b1; READY = 1'b1;
        for (int c = 0; c < 20 && !found; c++) begin
            tick();
            if (DACK === 4'b0001 && ADSTB === 1'b0) found = 1'b1;
        end
        total_cnt++;
        if (!found) $display("FAIL ready_s2_timeout: got no S2 want S2 within 20 cycles");
        else pass_cnt++;
        READY = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if ({IOR_N, MEMW_N} !== 2'b00 || incrAddr !== 1'b0) lowok = 1'b0;
            if (k == 3) READY = 1'b1;
        end
        total_cnt++;
        if (!lowok) $display("FAIL ready_wait: got strobes released during S3 want held 4 cycles");
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({incrAddr, EOP} !== 2'b10) $display("FAIL ready_s4: got %b want 10", {incrAddr, EOP});
        else pass_cnt++;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            tick();
            if (ADSTB) DREQ = 4'b0;
            if (incrAddr) found = 1'b1;
        end
        total_cnt++;
        if (EOP !== 1'b1) $display("FAIL ready_tc: got eop=%b want 1", EOP);
        else pass_cnt++;
        tick();
        HLDA = 1'b0;
        total_cnt++;
        if (obs_q.size() != exp_q.size()) $display("FAIL ready_events: got %0d want %0d", obs_q.size(), exp_q.size());
        else pass_cnt++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total_cnt++;
            if (o !== e) $display("FAIL ready_ev: got ch%0d eop%b want ch%0d eop%b", o.ch, o.eop, e.ch, e.eop);
            else pass_cnt++;
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_cs_abort();
        logic held;
        held = 1'b1;
        load_ch(0, 16'd0);
        CS_N = 1'b0; HLDA = 1'b0; DREQ = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (HRQ !== 1'b0) held = 1'b0;
        end
        total_cnt++;
        if (!held) $display("FAIL cs_block: got HRQ during CS_N=0 want 0");
        else pass_cnt++;
        CS_N = 1'b1;
        tick();
        total_cnt++;
        if ({HRQ, AEN} !== 2'b10) $display("FAIL cs_so: got %b want 10", {HRQ, AEN});
        else pass_cnt++;
        DREQ = 4'b0;
        tick();
        total_cnt++;
        if ({HRQ, AEN, tcStatus[0]} !== 3'b000) $display("FAIL so_abort: got %b want 000", {HRQ, AEN, tcStatus[0]});
        else pass_cnt++;
        total_cnt++;
        if (obs_q.size() != 0) $display("FAIL cs_events: got %0d want 0", obs_q.size());
        else pass_cnt++;
        obs_q.delete();
    endtask

`ifdef DMA_AUTOINIT_EN
    task automatic test_autoinit();
        ev_t e, o;
        int incn;
        incn = 0;
        blockMode = 4'b0; xferType = 8'b00_00_00_01;
        load_ch(0, 16'd1);
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(ev_t'{2'd0, 1'b0});
            exp_q.push_back(ev_t'{2'd0, 1'b1});
        end
        DREQ = 4'b0001; HLDA = 1'b1;
        for (int c = 0; c < 80 && incn < 4; c++) begin
            tick();
            if (incrAddr) incn++;
            if (incn == 3 && ADSTB) DREQ = 4'b0;
        end
        tick();
        total_cnt++;
        if ({HRQ, tcStatus[0]} !== 2'b01) $display("FAIL auto_idle: got %b want 01", {HRQ, tcStatus[0]});
        else pass_cnt++;
        HLDA = 1'b0;
        total_cnt++;
        if (obs_q.size() != exp_q.size()) $display("FAIL auto_events: got %0d want %0d", obs_q.size(), exp_q.size());
        else pass_cnt++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total_cnt++;
            if (o !== e) $display("FAIL auto_ev: got ch%0d eop%b want ch%0d eop%b", o.ch, o.eop, e.ch, e.eop);
            else pass_cnt++;
        end
        exp_q.delete(); obs_q.delete();
    endtask
`else
    task automatic test_no_rearm();
        ev_t e, o;
        logic idle;
        idle = 1'b1;
        blockMode = 4'b0; xferType = 8'b00_00_00_01;
        load_ch(0, 16'd0);
        exp_q.push_back(ev_t'{2'd0, 1'b1});
        DREQ = 4'b0001; HLDA = 1'b1;
        for (int c = 0; c < 20 && obs_q.size() < 1; c++) tick();
        for (int k = 0; k < 6; k++) begin
            tick();
            if (HRQ !== 1'b0) idle = 1'b0;
        end
        total_cnt++;
        if (!idle) $display("FAIL no_rearm: got HRQ after TC with DREQ held want idle");
        else pass_cnt++;
        DREQ = 4'b0; HLDA = 1'b0;
        total_cnt++;
        if (obs_q.size() != exp_q.size()) $display("FAIL norearm_events: got %0d want %0d", obs_q.size(), exp_q.size());
        else pass_cnt++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total_cnt++;
            if (o !== e) $display("FAIL norearm_ev: got ch%0d eop%b want ch%0d eop%b", o.ch, o.eop, e.ch, e.eop);
            else pass_cnt++;
        end
        exp_q.delete(); obs_q.delete();
    endtask
`endif

    task automatic test_reset_mid();
        logic found;
        found = 1'b0;
        blockMode = 4'b0; xferType = 8'b00_00_01_00;
        load_ch(1, 16'd5);
        DREQ = 4'b0010; HLDA = 1'b1;
        for (int c = 0; c < 20 && !found; c++) begin
            tick();
            if (DACK === 4'b0010 && ADSTB === 1'b0) found = 1'b1;
        end
        total_cnt++;
        if (!found) $display("FAIL rstmid_s2_timeout: got no S2 want S2 within 20 cycles");
        else pass_cnt++;
        RESET = 1'b1;
        #1;
        total_cnt++;
        if ({HRQ, AEN, ADSTB, EOP, incrAddr, DACK} !== 9'b0)
            $display("FAIL rstmid_ctrl: got %b want 000000000", {HRQ, AEN, ADSTB, EOP, incrAddr, DACK});
        else pass_cnt++;
        total_cnt++;
        if ({IOR_N, IOW_N, MEMR_N, MEMW_N} !== 4'b1111 || tcStatus !== 4'b0 || activeCh !== 2'd0)
            $display("FAIL rstmid_out: got strobes=%b tc=%b ch=%0d want 1111/0000/0", {IOR_N, IOW_N, MEMR_N, MEMW_N}, tcStatus, activeCh);
        else pass_cnt++;
        RESET = 1'b0;
        DREQ = 4'b0;
        tick();
        total_cnt++;
        if ({HRQ, EOP} !== 2'b00) $display("FAIL rstmid_idle: got %b want 00", {HRQ, EOP});
        else pass_cnt++;
        total_cnt++;
        if (obs_q.size() != 0) $display("FAIL rstmid_events: got %0d want 0", obs_q.size());
        else pass_cnt++;
        obs_q.delete();
        HLDA = 1'b0;
    endtask

    initial begin
        RESET = 1'b1; HLDA = 1'b0; READY = 1'b1; CS_N = 1'b1;
        DREQ = 4'b0; chEnable = 4'b0; blockMode = 4'b0; loadCount = 4'b0;
        xferType = 8'b0; countIn = 16'd0;
        test_reset();
        test_single();
        test_priority();
        test_block();
        test_ready();
        test_cs_abort();
`ifdef DMA_AUTOINIT_EN
        test_autoinit();
`else
        test_no_rearm();
`endif
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
